// File: rtl/keccak_absorb_if.sv
// Handshake and control bundle between the absorb tracker and its surrounding sponge logic.
interface keccak_absorb_if #(
    parameter int W              = 64,
    parameter int LEN_WIDTH      = 32,
    parameter int MAX_RATE_WORDS = 1344 / W
);
    localparam int BPW = W / 8;

    logic                              start;
    logic [2:0]                        mode;
    logic [LEN_WIDTH-1:0]              msg_len;
    logic                              in_valid;
    logic                              in_ready;
    logic                              out_valid;
    logic                              out_ready;
    logic [$clog2(BPW+1)-1:0]          word_bytes;
    logic [$clog2(MAX_RATE_WORDS)-1:0] word_idx;
    logic                              pad_first;
    logic                              pad_last;
    logic                              block_done;
    logic                              perm_done;
    logic                              busy;
    logic                              msg_done;
    logic [LEN_WIDTH-1:0]              block_count;

    modport master (
        output start, mode, msg_len, in_valid, out_ready, perm_done,
        input  in_ready, out_valid, word_bytes, word_idx, pad_first, pad_last,
               block_done, busy, msg_done, block_count
    );

    modport slave (
        input  start, mode, msg_len, in_valid, out_ready, perm_done,
        output in_ready, out_valid, word_bytes, word_idx, pad_first, pad_last,
               block_done, busy, msg_done, block_count
    );
endinterface

// File: rtl/keccak_absorb_tracker.sv
// Paces lane-wide message words into the Keccak state, marking pad bytes and waiting on permutations.
// Optional block counter enabled by defining ABSORB_BLOCK_COUNT_EN.
module keccak_absorb_tracker #(
    parameter int W              = 64,
    parameter int LEN_WIDTH      = 32,
    parameter int MAX_RATE_WORDS = 1344 / W
) (
    input logic             clk,
    input logic             rst,
    keccak_absorb_if.slave  bus
);
    localparam int BPW = W / 8;
    localparam int BW  = $clog2(BPW + 1);
    localparam int IW  = $clog2(MAX_RATE_WORDS);

    typedef enum logic [1:0] {IDLE, ABSORB, WAIT_PERM} state_t;

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] bytes_left_q, bytes_left_d;
    logic [IW-1:0]        word_idx_q, word_idx_d;
    logic [IW-1:0]        last_idx_q, last_idx_d;
    logic                 pad_seen_q, pad_seen_d;
    logic                 block_done_q, block_done_d;
    logic                 msg_done_q, msg_done_d;

    logic                 out_valid, in_ready, pad_first, pad_last;
    logic [BW-1:0]        word_bytes;
    logic                 short_left;
    logic                 last_lane;

    // Index of the last rate lane for a mode; unused encodings fall back to SHA3-256.
    function automatic logic [IW-1:0] rate_last(input logic [2:0] m);
        int unsigned rate_bytes;
        case (m)
            3'd0:    rate_bytes = 144;
            3'd1:    rate_bytes = 136;
            3'd2:    rate_bytes = 104;
            3'd3:    rate_bytes = 72;
            3'd4:    rate_bytes = 168;
            3'd5:    rate_bytes = 136;
            default: rate_bytes = 136;
        endcase
        return IW'(rate_bytes / BPW - 1);
    endfunction

    assign short_left = (bytes_left_q < LEN_WIDTH'(BPW));
    assign last_lane  = (word_idx_q == last_idx_q);

    always_comb begin
        state_d      = state_q;
        bytes_left_d = bytes_left_q;
        word_idx_d   = word_idx_q;
        last_idx_d   = last_idx_q;
        pad_seen_d   = pad_seen_q;
        block_done_d = 1'b0;
        msg_done_d   = 1'b0;
        out_valid    = 1'b0;
        in_ready     = 1'b0;
        word_bytes   = '0;
        pad_first    = 1'b0;
        pad_last     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bytes_left_d = bus.msg_len;
                    last_idx_d   = rate_last(bus.mode);
                    word_idx_d   = '0;
                    pad_seen_d   = 1'b0;
                    state_d      = ABSORB;
                end
            end

            ABSORB: begin
                if (pad_seen_q) begin
                    out_valid = 1'b1;
                end else if (bytes_left_q == '0) begin
                    out_valid = 1'b1;
                    pad_first = 1'b1;
                end else begin
                    out_valid  = bus.in_valid;
                    in_ready   = bus.out_ready;
                    word_bytes = short_left ? BW'(bytes_left_q) : BW'(BPW);
                    pad_first  = short_left;
                end

                // A full data lane in the final position defers all padding to the next block.
                pad_last = out_valid && last_lane && (pad_seen_q || short_left);

                if (out_valid && bus.out_ready) begin
                    if (LEN_WIDTH'(word_bytes) >= bytes_left_q)
                        bytes_left_d = '0;
                    else
                        bytes_left_d = bytes_left_q - LEN_WIDTH'(word_bytes);
                    if (pad_first)
                        pad_seen_d = 1'b1;
                    if (last_lane) begin
                        word_idx_d   = '0;
                        block_done_d = 1'b1;
                        state_d      = WAIT_PERM;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end

            WAIT_PERM: begin
                if (bus.perm_done) begin
                    if (pad_seen_q) begin
                        state_d    = IDLE;
                        msg_done_d = 1'b1;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bytes_left_q <= '0;
            word_idx_q   <= '0;
            last_idx_q   <= '0;
            pad_seen_q   <= 1'b0;
            block_done_q <= 1'b0;
            msg_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bytes_left_q <= bytes_left_d;
            word_idx_q   <= word_idx_d;
            last_idx_q   <= last_idx_d;
            pad_seen_q   <= pad_seen_d;
            block_done_q <= block_done_d;
            msg_done_q   <= msg_done_d;
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.in_ready   = in_ready;
    assign bus.word_bytes = word_bytes;
    assign bus.word_idx   = word_idx_q;
    assign bus.pad_first  = pad_first;
    assign bus.pad_last   = pad_last;
    assign bus.block_done = block_done_q;
    assign bus.msg_done   = msg_done_q;
    assign bus.busy       = (state_q != IDLE);

`ifdef ABSORB_BLOCK_COUNT_EN
    logic [LEN_WIDTH-1:0] block_count_q, block_count_d;

    always_comb begin
        block_count_d = block_count_q;
        if (state_q == IDLE && bus.start)
            block_count_d = '0;
        else if (block_done_d && !(&block_count_q))
            block_count_d = block_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            block_count_q <= '0;
        else
            block_count_q <= block_count_d;
    end

    assign bus.block_count = block_count_q;
`else
    assign bus.block_count = '0;
`endif

endmodule

// File: tb/tb_keccak_absorb_tracker.sv
// Directed bench for keccak_absorb_tracker at W=64 (BPW=8).
module tb_keccak_absorb_tracker;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    keccak_absorb_if #(.W(64), .LEN_WIDTH(32), .MAX_RATE_WORDS(21)) bus ();

    keccak_absorb_tracker #(.W(64), .LEN_WIDTH(32), .MAX_RATE_WORDS(21)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [18:0] got;
        rst = 1'b0;
        bus.start = 1'b0; bus.mode = 3'd0; bus.msg_len = '0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.perm_done = 1'b1;
        #3;
        got = {bus.out_valid, bus.in_ready, bus.busy, bus.block_done, bus.msg_done,
               bus.pad_first, bus.pad_last, bus.word_bytes, bus.word_idx, bus.block_count[3:0]};
        checks++;
        if (got !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", got); end
        tick;
        bus.in_valid = 1'b0; bus.perm_done = 1'b0;
        rst = 1'b1;
        tick;
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle busy=%0b out_valid=%0b exp=0,0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_empty_msg;
        logic [12:0] got, exp_v;
        bus.mode = 3'd1; bus.msg_len = 32'd0; bus.start = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick; bus.start = 1'b0; #1;
            exp_v = {1'b1, 1'b0, 4'd0, 5'(i), (i == 0), (i == 16)};
            got   = {bus.out_valid, bus.in_ready, bus.word_bytes, bus.word_idx, bus.pad_first, bus.pad_last};
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL empty_slot idx=%0d got=%h exp=%h", i, got, exp_v); end
        end
        tick;
        checks++;
        if (bus.block_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL empty_blkdone bd=%0b ov=%0b busy=%0b exp=1,0,1", bus.block_done, bus.out_valid, bus.busy);
        end
        bus.perm_done = 1'b1;
        tick; bus.perm_done = 1'b0; #1;
        checks++;
        if (bus.msg_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL empty_msgdone md=%0b busy=%0b exp=1,0", bus.msg_done, bus.busy);
        end
        tick;
        checks++;
        if (bus.msg_done !== 1'b0) begin errors++; $display("FAIL empty_msgdone_pulse got=%0b exp=0", bus.msg_done); end
    endtask

    task automatic test_exact_block;
        logic [12:0] got, exp_v;
        logic [31:0] exp_cnt;
        bus.mode = 3'd1; bus.msg_len = 32'd136; bus.start = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick; bus.start = 1'b0; #1;
            exp_v = {1'b1, 1'b1, 4'd8, 5'(i), 1'b0, 1'b0};
            got   = {bus.out_valid, bus.in_ready, bus.word_bytes, bus.word_idx, bus.pad_first, bus.pad_last};
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL exact_blk0 idx=%0d got=%h exp=%h", i, got, exp_v); end
        end
        tick;
        checks++;
        if (bus.block_done !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL exact_wait0 bd=%0b ov=%0b ir=%0b exp=1,0,0", bus.block_done, bus.out_valid, bus.in_ready);
        end
        bus.start = 1'b1; bus.msg_len = 32'd99; bus.mode = 3'd3;
        tick; bus.start = 1'b0; #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.block_done !== 1'b0) begin
            errors++; $display("FAIL exact_start_ignored busy=%0b ov=%0b bd=%0b exp=1,0,0", bus.busy, bus.out_valid, bus.block_done);
        end
        bus.perm_done = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick; bus.perm_done = 1'b0; #1;
            exp_v = {1'b1, 1'b0, 4'd0, 5'(i), (i == 0), (i == 16)};
            got   = {bus.out_valid, bus.in_ready, bus.word_bytes, bus.word_idx, bus.pad_first, bus.pad_last};
            checks++;
            if (got !== exp_v || bus.msg_done !== 1'b0) begin
                errors++; $display("FAIL exact_blk1 idx=%0d got=%h md=%0b exp=%h md=0", i, got, bus.msg_done, exp_v);
            end
        end
        tick;
        checks++;
        if (bus.block_done !== 1'b1) begin errors++; $display("FAIL exact_blkdone1 got=%0b exp=1", bus.block_done); end
        bus.perm_done = 1'b1;
        tick; bus.perm_done = 1'b0; #1;
`ifdef ABSORB_BLOCK_COUNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (bus.msg_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL exact_msgdone md=%0b busy=%0b exp=1,0", bus.msg_done, bus.busy);
        end
        checks++;
        if (bus.block_count !== exp_cnt) begin
            errors++; $display("FAIL exact_blkcount got=%0d exp=%0d", bus.block_count, exp_cnt);
        end
    endtask

    task automatic test_partial_last;
        logic [12:0] got, exp_v;
        bus.mode = 3'd1; bus.msg_len = 32'd135; bus.start = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick; bus.start = 1'b0; #1;
            exp_v = (i == 16) ? {1'b1, 1'b1, 4'd7, 5'd16, 1'b1, 1'b1}
                              : {1'b1, 1'b1, 4'd8, 5'(i), 1'b0, 1'b0};
            got   = {bus.out_valid, bus.in_ready, bus.word_bytes, bus.word_idx, bus.pad_first, bus.pad_last};
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL partial_slot idx=%0d got=%h exp=%h", i, got, exp_v); end
        end
        tick;
        bus.perm_done = 1'b1;
        tick; bus.perm_done = 1'b0; #1;
        checks++;
        if (bus.msg_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL partial_one_block md=%0b busy=%0b exp=1,0", bus.msg_done, bus.busy);
        end
    endtask

    task automatic test_stall;
        logic [12:0] got, exp_v;
        logic [3:0]  wb;
        bus.mode = 3'd3; bus.msg_len = 32'd20; bus.start = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wb = (i < 2) ? 4'd8 : (i == 2) ? 4'd4 : 4'd0;
            tick; bus.start = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0; #1;
            exp_v = {(i >= 3), 1'b0, wb, 5'(i), (i == 2), (i == 8)};
            got   = {bus.out_valid, bus.in_ready, bus.word_bytes, bus.word_idx, bus.pad_first, bus.pad_last};
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL stall_hold idx=%0d got=%h exp=%h", i, got, exp_v); end
            tick; bus.out_ready = 1'b1; bus.in_valid = (i < 3); #1;
            exp_v = {1'b1, (i < 3), wb, 5'(i), (i == 2), (i == 8)};
            got   = {bus.out_valid, bus.in_ready, bus.word_bytes, bus.word_idx, bus.pad_first, bus.pad_last};
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL stall_accept idx=%0d got=%h exp=%h", i, got, exp_v); end
        end
        tick;
        checks++;
        if (bus.block_done !== 1'b1) begin errors++; $display("FAIL stall_blkdone got=%0b exp=1", bus.block_done); end
        bus.perm_done = 1'b1;
        tick; bus.perm_done = 1'b0; #1;
        checks++;
        if (bus.msg_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL stall_msgdone md=%0b busy=%0b exp=1,0", bus.msg_done, bus.busy);
        end
    endtask

    task automatic test_mid_reset;
        logic [12:0] got, exp_v;
        logic [4:0]  rgot;
        bus.mode = 3'd1; bus.msg_len = 32'd200; bus.start = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick; bus.start = 1'b0;
        end
        #1;
        checks++;
        if (bus.word_idx !== 5'd5 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL midrst_pre idx=%0d ov=%0b exp=5,1", bus.word_idx, bus.out_valid);
        end
        rst = 1'b0;
        #1;
        rgot = {bus.out_valid, bus.in_ready, bus.busy, bus.pad_first, bus.pad_last};
        checks++;
        if (rgot !== 5'd0 || bus.word_idx !== 5'd0 || bus.word_bytes !== 4'd0) begin
            errors++; $display("FAIL midrst_outputs got=%h idx=%0d wb=%0d exp=0", rgot, bus.word_idx, bus.word_bytes);
        end
        tick; rst = 1'b1;
        tick;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle busy=%0b exp=0", bus.busy); end
        bus.msg_len = 32'd10; bus.start = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick; bus.start = 1'b0; #1;
            exp_v = (i == 0) ? {1'b1, 1'b1, 4'd8, 5'd0, 1'b0, 1'b0} :
                    (i == 1) ? {1'b1, 1'b1, 4'd2, 5'd1, 1'b1, 1'b0} :
                               {1'b1, 1'b0, 4'd0, 5'(i), 1'b0, (i == 16)};
            got   = {bus.out_valid, bus.in_ready, bus.word_bytes, bus.word_idx, bus.pad_first, bus.pad_last};
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL midrst_fresh idx=%0d got=%h exp=%h", i, got, exp_v); end
        end
        tick;
        bus.perm_done = 1'b1;
        tick; bus.perm_done = 1'b0; #1;
        checks++;
        if (bus.msg_done !== 1'b1) begin errors++; $display("FAIL midrst_msgdone got=%0b exp=1", bus.msg_done); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_empty_msg;
        test_exact_block;
        test_partial_last;
        test_stall;
        test_mid_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
